// File: rtl/alu_sequencer.sv
// alu_sequencer: instruction-issue front end for a combinational 16-bit ALU.
// Decodes {op, rd, ra, rb} instruction words, drives the ALU from a 16-entry
// register file, writes the result back and presents it on a result handshake.
module alu_sequencer (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [15:0] instr,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    output logic [3:0]  alu_op,
    input  logic [15:0] alu_result,
    output logic        result_valid,
    input  logic        result_ready,
    output logic [15:0] result_data,
    output logic [3:0]  result_rd,
    output logic        illegal
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_RESP
    } state_t;

    localparam logic [3:0] OP_LDI = 4'hF;

    state_t      state;
    state_t      state_nxt;
    logic [15:0] instr_q;
    logic [15:0] regs [16];

    logic        accept;
    logic        in_is_alu;
    logic [15:0] rf_a;
    logic [15:0] rf_b;
    logic [3:0]  op_q;
    logic [3:0]  rd_q;
    logic        exec_alu;
    logic        exec_ldi;
    logic        exec_write;
    logic [15:0] wb_data;

    // Decode of the incoming word and of the latched instruction.
    always_comb begin
        accept     = (state == S_IDLE) && instr_valid;
        in_is_alu  = (instr[15:14] == 2'b00);
        rf_a       = (instr[7:4] == 4'h0) ? '0 : regs[instr[7:4]];
        rf_b       = (instr[3:0] == 4'h0) ? '0 : regs[instr[3:0]];
        op_q       = instr_q[15:12];
        rd_q       = instr_q[11:8];
        exec_alu   = (state == S_EXEC) && (op_q[3:2] == 2'b00);
        exec_ldi   = (state == S_EXEC) && (op_q == OP_LDI);
        exec_write = exec_alu || exec_ldi;
        wb_data    = exec_ldi ? {8'h00, instr_q[7:0]} : alu_result;
    end

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake/illegal outputs.
    always_comb begin
        state_nxt    = state;
        instr_ready  = 1'b0;
        result_valid = 1'b0;
        illegal      = 1'b0;
        case (state)
            S_IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid) begin
                    state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                if (exec_write) begin
                    state_nxt = S_RESP;
                end else begin
                    illegal   = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            S_RESP: begin
                result_valid = 1'b1;
                if (result_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Instruction latch and ALU input registers; operands are read at accept
    // so they are stable for the whole EXEC cycle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            instr_q <= '0;
            alu_a   <= '0;
            alu_b   <= '0;
            alu_op  <= '0;
        end else if (accept) begin
            instr_q <= instr;
            if (in_is_alu) begin
                alu_a  <= rf_a;
                alu_b  <= rf_b;
                alu_op <= instr[15:12];
            end
        end
    end

    // Register file write-back; r0 is never written.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            regs <= '{default: '0};
        end else if (exec_write && (rd_q != 4'h0)) begin
            regs[rd_q] <= wb_data;
        end
    end

    // Result registers, held through RESP until the consumer takes them.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            result_data <= '0;
            result_rd   <= '0;
        end else if (exec_write) begin
            result_data <= wb_data;
            result_rd   <= rd_q;
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Testbench for alu_sequencer: table of directed instructions with
// hand-computed results, plus hand sequences for back-pressure and reset.
module tb_alu_sequencer;

    logic        clock;
    logic        reset_n;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [3:0]  alu_op;
    logic [15:0] alu_result;
    logic        result_valid;
    logic        result_ready;
    logic [15:0] result_data;
    logic [3:0]  result_rd;
    logic        illegal;

    int checks   = 0;
    int failures = 0;

    alu_sequencer dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .instr        (instr),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_op       (alu_op),
        .alu_result   (alu_result),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .result_data  (result_data),
        .result_rd    (result_rd),
        .illegal      (illegal)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Combinational ALU the sequencer drives.
    always_comb begin
        case (alu_op)
            4'h0:    alu_result = alu_a + alu_b;
            4'h1:    alu_result = alu_a - alu_b;
            4'h2:    alu_result = alu_a & alu_b;
            4'h3:    alu_result = alu_a | alu_b;
            default: alu_result = 16'h0000;
        endcase
    end

    typedef struct {
        logic [15:0] word;
        logic        ill;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] data;
        logic [3:0]  rd;
    } vec_t;

    vec_t vecs [$];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Issue one instruction with result_ready high and check every phase.
    task automatic do_instr(input vec_t v);
        logic [3:0] op;
        op = v.word[15:12];
        @(negedge clock);
        instr       = v.word;
        instr_valid = 1'b1;
        chk("ready_before_accept", {15'd0, instr_ready}, 16'd1);
        @(posedge clock);
        #1;
        instr_valid = 1'b0;
        chk("ready_in_exec", {15'd0, instr_ready}, 16'd0);
        chk("illegal_in_exec", {15'd0, illegal}, {15'd0, v.ill});
        chk("valid_in_exec", {15'd0, result_valid}, 16'd0);
        if (!v.ill && op != 4'hF) begin
            chk("alu_op", {12'd0, alu_op}, {12'd0, op});
            chk("alu_a", alu_a, v.a);
            chk("alu_b", alu_b, v.b);
        end
        @(posedge clock);
        #1;
        if (v.ill) begin
            chk("illegal_after", {15'd0, illegal}, 16'd0);
            chk("valid_after_illegal", {15'd0, result_valid}, 16'd0);
            chk("ready_after_illegal", {15'd0, instr_ready}, 16'd1);
        end else begin
            chk("result_valid", {15'd0, result_valid}, 16'd1);
            chk("result_data", result_data, v.data);
            chk("result_rd", {12'd0, result_rd}, {12'd0, v.rd});
            chk("illegal_resp", {15'd0, illegal}, 16'd0);
            @(posedge clock);
            #1;
            chk("valid_after_resp", {15'd0, result_valid}, 16'd0);
            chk("ready_after_resp", {15'd0, instr_ready}, 16'd1);
        end
    endtask

    function automatic vec_t mk(input logic [15:0] w, input logic il, input logic [15:0] a,
                                input logic [15:0] b, input logic [15:0] d, input logic [3:0] rd);
        vec_t v;
        v.word = w; v.ill = il; v.a = a; v.b = b; v.data = d; v.rd = rd;
        return v;
    endfunction

    initial begin
        vec_t v;
        reset_n      = 1'b0;
        instr_valid  = 1'b0;
        instr        = 16'h0000;
        result_ready = 1'b1;

        // Table: word, illegal, alu_a, alu_b, result_data, result_rd
        vecs.push_back(mk(16'hF12A, 0, 16'h0000, 16'h0000, 16'h002A, 4'd1));
        vecs.push_back(mk(16'hF1FF, 0, 16'h0000, 16'h0000, 16'h00FF, 4'd1));
        vecs.push_back(mk(16'hF2FF, 0, 16'h0000, 16'h0000, 16'h00FF, 4'd2));
        vecs.push_back(mk(16'h0111, 0, 16'h00FF, 16'h00FF, 16'h01FE, 4'd1));
        vecs.push_back(mk(16'h0111, 0, 16'h01FE, 16'h01FE, 16'h03FC, 4'd1));
        vecs.push_back(mk(16'h0111, 0, 16'h03FC, 16'h03FC, 16'h07F8, 4'd1));
        vecs.push_back(mk(16'hF201, 0, 16'h0000, 16'h0000, 16'h0001, 4'd2));
        vecs.push_back(mk(16'h1102, 0, 16'h0000, 16'h0001, 16'hFFFF, 4'd1));
        vecs.push_back(mk(16'h0312, 0, 16'hFFFF, 16'h0001, 16'h0000, 4'd3));
        vecs.push_back(mk(16'hF1F0, 0, 16'h0000, 16'h0000, 16'h00F0, 4'd1));
        vecs.push_back(mk(16'hF23C, 0, 16'h0000, 16'h0000, 16'h003C, 4'd2));
        vecs.push_back(mk(16'h1412, 0, 16'h00F0, 16'h003C, 16'h00B4, 4'd4));
        vecs.push_back(mk(16'h2512, 0, 16'h00F0, 16'h003C, 16'h0030, 4'd5));
        vecs.push_back(mk(16'h3612, 0, 16'h00F0, 16'h003C, 16'h00FC, 4'd6));
        vecs.push_back(mk(16'h0745, 0, 16'h00B4, 16'h0030, 16'h00E4, 4'd7));
        vecs.push_back(mk(16'h7123, 1, 16'h0000, 16'h0000, 16'h0000, 4'd0));
        vecs.push_back(mk(16'h0A10, 0, 16'h00F0, 16'h0000, 16'h00F0, 4'd10));
        vecs.push_back(mk(16'hF055, 0, 16'h0000, 16'h0000, 16'h0055, 4'd0));
        vecs.push_back(mk(16'h0800, 0, 16'h0000, 16'h0000, 16'h0000, 4'd8));
        vecs.push_back(mk(16'h4000, 1, 16'h0000, 16'h0000, 16'h0000, 4'd0));
        vecs.push_back(mk(16'hEFFF, 1, 16'h0000, 16'h0000, 16'h0000, 4'd0));
        vecs.push_back(mk(16'h0BF0, 0, 16'h0000, 16'h0000, 16'h0000, 4'd11));

        // Reset state.
        repeat (2) @(posedge clock);
        #1;
        chk("rst_instr_ready", {15'd0, instr_ready}, 16'd1);
        chk("rst_result_valid", {15'd0, result_valid}, 16'd0);
        chk("rst_illegal", {15'd0, illegal}, 16'd0);
        chk("rst_alu_a", alu_a, 16'h0000);
        chk("rst_alu_b", alu_b, 16'h0000);
        chk("rst_alu_op", {12'd0, alu_op}, 16'h0000);
        chk("rst_result_data", result_data, 16'h0000);
        chk("rst_result_rd", {12'd0, result_rd}, 16'h0000);
        @(negedge clock);
        reset_n = 1'b1;

        foreach (vecs[i]) do_instr(vecs[i]);

        // Back-pressure: RESP held 5 cycles with instr_valid high throughout.
        @(negedge clock);
        instr        = 16'hF3AB;
        instr_valid  = 1'b1;
        result_ready = 1'b0;
        @(posedge clock);
        #1;
        instr = 16'hF4CD;
        @(posedge clock);
        #1;
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", {15'd0, result_valid}, 16'd1);
            chk("bp_data", result_data, 16'h00AB);
            chk("bp_rd", {12'd0, result_rd}, 16'd3);
            chk("bp_ready", {15'd0, instr_ready}, 16'd0);
            @(posedge clock);
            #1;
        end
        @(negedge clock);
        result_ready = 1'b1;
        @(posedge clock);
        #1;
        instr_valid = 1'b0;
        chk("bp_release_valid", {15'd0, result_valid}, 16'd0);
        chk("bp_release_ready", {15'd0, instr_ready}, 16'd1);
        // r4 must be untouched by the word presented during back-pressure.
        do_instr(mk(16'h0C40, 0, 16'h00B4, 16'h0000, 16'h00B4, 4'd12));

        // Reset asserted during EXEC.
        @(negedge clock);
        instr       = 16'h0512;
        instr_valid = 1'b1;
        @(posedge clock);
        #1;
        instr_valid = 1'b0;
        chk("pre_rst_exec_alu_a", alu_a, 16'h00F0);
        #1;
        reset_n = 1'b0;
        #1;
        chk("rst_exec_ready", {15'd0, instr_ready}, 16'd1);
        chk("rst_exec_alu_a", alu_a, 16'h0000);
        chk("rst_exec_alu_op", {12'd0, alu_op}, 16'h0000);
        chk("rst_exec_illegal", {15'd0, illegal}, 16'd0);
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        chk("rst_exec_no_result", {15'd0, result_valid}, 16'd0);

        // Reset asserted during RESP.
        @(negedge clock);
        instr        = 16'hF211;
        instr_valid  = 1'b1;
        result_ready = 1'b0;
        @(posedge clock);
        #1;
        instr_valid = 1'b0;
        @(posedge clock);
        #1;
        chk("pre_rst_resp_valid", {15'd0, result_valid}, 16'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("rst_resp_valid", {15'd0, result_valid}, 16'd0);
        chk("rst_resp_data", result_data, 16'h0000);
        chk("rst_resp_rd", {12'd0, result_rd}, 16'h0000);
        @(negedge clock);
        reset_n      = 1'b1;
        result_ready = 1'b1;

        // All registers cleared: r9 = r1 + r2 = 0.
        v = mk(16'h0912, 0, 16'h0000, 16'h0000, 16'h0000, 4'd9);
        do_instr(v);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
